// File: rtl/arcade_input_mapper.sv
// -----------------------------------------------------------------------------
// arcade_input_mapper
//
// Merges a PS/2 keyboard event stream and per-player joystick vectors into
// one registered, active-high button vector per player, with optional screen
// rotation of the direction bits, a fixed-length coin pulse and an optional
// per-player autofire.
//
// Build option: define AUTOFIRE_EN to enable autofire on the fire button.
// Without it, vblank and af_mask are ignored (the port list is unchanged).
//
// Parameters
//   NUM_PLAYERS  player channels (1..4)
//   COIN_PULSE   coin output pulse length in clock cycles (1..255)
//   AF_FRAMES    autofire half-period in vblank rising edges (1..15)
//
// Ports
//   CLK       system clock, rising edge
//   RESET     synchronous, active-high reset
//   ps2_key   [10] toggles per event, [9] pressed, [8:0] scan code
//   joy       16 bits per player; bits 0..7 = right,left,down,up,fire,start,skip,coin
//   rotate    00 none, 01 CW, 10 CCW, 11 180 (direction bits only)
//   vblank    frame marker used for autofire timing
//   af_mask   per-player autofire enable
//   btn       8 bits per player, same bit order as joy
// -----------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int COIN_PULSE  = 16,
    parameter int AF_FRAMES   = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic [1:0]                rotate,
    input  logic                      vblank,
    input  logic [NUM_PLAYERS-1:0]    af_mask,
    output logic [8*NUM_PLAYERS-1:0]  btn
);

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int FIRE  = 4;
    localparam int START = 5;
    localparam int SKIP  = 6;
    localparam int COIN  = 7;

    // Returns {up, down, left, right} after applying the screen rotation.
    function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input logic [1:0] r);
        case (r)
            2'b01:   rotate_dirs = {d[LEFT],  d[RIGHT], d[DOWN],  d[UP]};
            2'b10:   rotate_dirs = {d[RIGHT], d[LEFT],  d[UP],    d[DOWN]};
            2'b11:   rotate_dirs = {d[DOWN],  d[UP],    d[RIGHT], d[LEFT]};
            default: rotate_dirs = d;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Keyboard: event detection and key latches
    // ------------------------------------------------------------------
    logic       toggle_reg;
    logic       key_event;
    logic [7:0] p1_hit;
    logic [7:0] p2_hit;
    logic [7:0] p1_key_reg;
    logic [7:0] p2_key_reg;

    assign key_event = ps2_key[10] ^ toggle_reg;

    always_comb begin
        p1_hit = '0;
        p2_hit = '0;
        // Arrows match on the low byte so extended and keypad codes both work.
        case (ps2_key[7:0])
            8'h74:   p1_hit[RIGHT] = 1'b1;
            8'h6B:   p1_hit[LEFT]  = 1'b1;
            8'h72:   p1_hit[DOWN]  = 1'b1;
            8'h75:   p1_hit[UP]    = 1'b1;
            default: ;
        endcase
        case (ps2_key[8:0])
            9'h029, 9'h014: p1_hit[FIRE]  = 1'b1;
            9'h016, 9'h005: p1_hit[START] = 1'b1;
            9'h003:         p1_hit[SKIP]  = 1'b1;
            9'h02E:         p1_hit[COIN]  = 1'b1;
            9'h02D:         p2_hit[UP]    = 1'b1;
            9'h02B:         p2_hit[DOWN]  = 1'b1;
            9'h023:         p2_hit[LEFT]  = 1'b1;
            9'h034:         p2_hit[RIGHT] = 1'b1;
            9'h01C:         p2_hit[FIRE]  = 1'b1;
            9'h01E, 9'h006: p2_hit[START] = 1'b1;
            9'h01B:         p2_hit[SKIP]  = 1'b1;
            9'h036:         p2_hit[COIN]  = 1'b1;
            default:        ;
        endcase
        if (NUM_PLAYERS < 2) begin
            p2_hit = '0;
        end
    end

    // The toggle copy also tracks during reset so leaving reset is not an event.
    always_ff @(posedge CLK) begin
        toggle_reg <= ps2_key[10];
        if (RESET) begin
            p1_key_reg <= '0;
            p2_key_reg <= '0;
        end else if (key_event) begin
            for (int i = 0; i < 8; i++) begin
                if (p1_hit[i]) p1_key_reg[i] <= ps2_key[9];
                if (p2_hit[i]) p2_key_reg[i] <= ps2_key[9];
            end
        end
    end

    // Player 2 latches have no consumer in a single-player build.
    logic unused_p2;
    assign unused_p2 = &{1'b0, p2_key_reg};

    // ------------------------------------------------------------------
    // Frame edge for autofire
    // ------------------------------------------------------------------
`ifdef AUTOFIRE_EN
    logic vblank_reg;
    logic vblank_rise;

    always_ff @(posedge CLK) begin
        if (RESET) vblank_reg <= 1'b0;
        else       vblank_reg <= vblank;
    end

    assign vblank_rise = vblank & ~vblank_reg;
`else
    logic unused_af;
    assign unused_af = &{1'b0, vblank, af_mask};
`endif

    // ------------------------------------------------------------------
    // Per-player merge, rotation, coin pulse and output register
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            logic [7:0] key_bits;
            logic [7:0] raw;
            logic [7:0] btn_reg;
            logic [7:0] btn_next;
            logic [7:0] coin_cnt_reg;
            logic [7:0] coin_cnt_next;
            logic       coin_prev_reg;
            logic       fire_out;
            logic       unused_joy;

            if (gi == 0) begin : g_keys_p1
                assign key_bits = p1_key_reg;
            end else if (gi == 1) begin : g_keys_p2
                assign key_bits = p2_key_reg;
            end else begin : g_keys_none
                assign key_bits = '0;
            end

            assign raw        = key_bits | joy[16*gi +: 8];
            assign unused_joy = &{1'b0, joy[16*gi+8 +: 8]};

            // Edge-triggered, non-retriggerable pulse; key and joy coin share one edge.
            always_comb begin
                coin_cnt_next = coin_cnt_reg;
                if (coin_cnt_reg != 8'd0) begin
                    coin_cnt_next = coin_cnt_reg - 8'd1;
                end else if (raw[COIN] && !coin_prev_reg) begin
                    coin_cnt_next = 8'(COIN_PULSE);
                end
            end

`ifdef AUTOFIRE_EN
            logic [3:0] af_cnt_reg;
            logic [3:0] af_cnt_next;
            logic       af_off_reg;
            logic       af_off_next;

            // af_off idles at 0 so the first frame of a press is always "on".
            always_comb begin
                af_cnt_next = af_cnt_reg;
                af_off_next = af_off_reg;
                if (!(raw[FIRE] && af_mask[gi])) begin
                    af_cnt_next = 4'd0;
                    af_off_next = 1'b0;
                end else if (vblank_rise) begin
                    if (af_cnt_reg == 4'(AF_FRAMES - 1)) begin
                        af_cnt_next = 4'd0;
                        af_off_next = ~af_off_reg;
                    end else begin
                        af_cnt_next = af_cnt_reg + 4'd1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    af_cnt_reg <= 4'd0;
                    af_off_reg <= 1'b0;
                end else begin
                    af_cnt_reg <= af_cnt_next;
                    af_off_reg <= af_off_next;
                end
            end

            assign fire_out = raw[FIRE] & ~(af_mask[gi] & af_off_reg);
`else
            assign fire_out = raw[FIRE];
`endif

            assign btn_next = {coin_cnt_next != 8'd0, raw[SKIP], raw[START], fire_out,
                               rotate_dirs(raw[3:0], rotate)};

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    coin_cnt_reg  <= 8'd0;
                    coin_prev_reg <= 1'b0;
                    btn_reg       <= '0;
                end else begin
                    coin_cnt_reg  <= coin_cnt_next;
                    coin_prev_reg <= raw[COIN];
                    btn_reg       <= btn_next;
                end
            end

            assign btn[8*gi +: 8] = btn_reg;
        end
    endgenerate

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;

    localparam int COIN_PULSE = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [10:0] ps2_key;
    logic [31:0] joy;
    logic [1:0]  rotate;
    logic        vblank;
    logic [1:0]  af_mask;
    logic [15:0] btn;
    logic [7:0]  btn1;

    int checks   = 0;
    int failures = 0;

    arcade_input_mapper #(
        .NUM_PLAYERS(2),
        .COIN_PULSE (COIN_PULSE),
        .AF_FRAMES  (2)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .ps2_key(ps2_key),
        .joy    (joy),
        .rotate (rotate),
        .vblank (vblank),
        .af_mask(af_mask),
        .btn    (btn)
    );

    // Single-player instance on the same stimulus: player-2 keys must be ignored.
    arcade_input_mapper #(
        .NUM_PLAYERS(1),
        .COIN_PULSE (COIN_PULSE),
        .AF_FRAMES  (2)
    ) dut1 (
        .CLK    (CLK),
        .RESET  (RESET),
        .ps2_key(ps2_key),
        .joy    (joy[15:0]),
        .rotate (rotate),
        .vblank (vblank),
        .af_mask(af_mask[0:0]),
        .btn    (btn1)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model: directions as clockwise quarter turns from "up",
    // rotation adds quarter turns; coin as a remaining-cycles count.
    // ------------------------------------------------------------------
    bit [15:0] m_keys;       // index = player*8 + button bit
    int        m_coin [2];
    bit        m_prev [2];
    bit        m_toggle;
    bit [15:0] m_exp;
    int        quarter_of [4] = '{1, 3, 2, 0};  // bit -> quarter (right,left,down,up)
    int        bit_of     [4] = '{3, 0, 2, 1};  // quarter -> bit

    function automatic int rot_quarters(input bit [1:0] r);
        case (r)
            2'b01:   return 1;
            2'b10:   return 3;
            2'b11:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int key_target(input bit [8:0] c);
        case (c)
            9'h075, 9'h175: return 3;
            9'h072, 9'h172: return 2;
            9'h06B, 9'h16B: return 1;
            9'h074, 9'h174: return 0;
            9'h029, 9'h014: return 4;
            9'h016, 9'h005: return 5;
            9'h003:         return 6;
            9'h02E:         return 7;
            9'h034:         return 8;
            9'h023:         return 9;
            9'h02B:         return 10;
            9'h02D:         return 11;
            9'h01C:         return 12;
            9'h01E, 9'h006: return 13;
            9'h01B:         return 14;
            9'h036:         return 15;
            default:        return -1;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit [7:0] raw;
        bit [7:0] o;
        int t;
        int q;
        if (RESET) begin
            m_keys   = '0;
            m_coin   = '{0, 0};
            m_prev   = '{0, 0};
            m_toggle = ps2_key[10];
            m_exp    = '0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            raw = m_keys[8*p +: 8] | joy[16*p +: 8];
            o = {1'b0, raw[6:4], 4'b0000};
            for (int d = 0; d < 4; d++) begin
                if (raw[d]) begin
                    q = (quarter_of[d] + rot_quarters(rotate)) % 4;
                    o[bit_of[q]] = 1'b1;
                end
            end
            if (m_coin[p] > 0)
                m_coin[p]--;
            else if (raw[7] && !m_prev[p])
                m_coin[p] = COIN_PULSE;
            m_prev[p] = raw[7];
            o[7] = (m_coin[p] > 0);
            m_exp[8*p +: 8] = o;
        end
        if (ps2_key[10] != m_toggle) begin
            t = key_target(ps2_key[8:0]);
            if (t >= 0) m_keys[t] = ps2_key[9];
        end
        m_toggle = ps2_key[10];
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit        rst;
        bit [10:0] ps2;
        bit [31:0] joy;
        bit [1:0]  rot;
        bit [15:0] exp;
        bit [7:0]  exp1;
        string     name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit [10:0] ps2, input bit [31:0] j,
                                input bit [1:0] r, input bit [15:0] e, input bit [7:0] e1,
                                input string n);
        vec_t v;
        v.rst = rst; v.ps2 = ps2; v.joy = j; v.rot = r; v.exp = e; v.exp1 = e1; v.name = n;
        vecs.push_back(v);
    endfunction

    bit [8:0] codes [24] = '{9'h075, 9'h175, 9'h072, 9'h06B, 9'h174, 9'h029, 9'h014, 9'h016,
                             9'h005, 9'h003, 9'h02E, 9'h02D, 9'h12D, 9'h02B, 9'h023, 9'h034,
                             9'h01C, 9'h006, 9'h036, 9'h114, 9'h01E, 9'h01B, 9'h000, 9'h1FF};

    initial begin
        int hi;
        int hi1;
        int first_hi;
        int tog;
        bit prev4;
        bit steady;

        RESET   = 1'b1;
        ps2_key = '0;
        joy     = '0;
        rotate  = 2'b00;
        vblank  = 1'b0;
        af_mask = 2'b00;

        //   rst  ps2       joy            rot    btn       btn1   name
        add(1, 11'h000, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "reset");
        add(0, 11'h000, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "idle");
        add(0, 11'h775, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "up_press_lat");
        add(0, 11'h775, 32'h0000_0000, 2'b00, 16'h0008, 8'h08, "up_press");
        add(0, 11'h175, 32'h0000_0000, 2'b00, 16'h0008, 8'h08, "up_rel_lat");
        add(0, 11'h175, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "up_rel");
        add(0, 11'h61C, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "p2_fire_lat");
        add(0, 11'h61C, 32'h0000_0000, 2'b00, 16'h1000, 8'h00, "p2_fire");
        add(0, 11'h01C, 32'h0000_0000, 2'b00, 16'h1000, 8'h00, "p2_fire_rel_lat");
        add(0, 11'h01C, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "p2_fire_rel");
        add(0, 11'h01C, 32'h0000_0002, 2'b01, 16'h0008, 8'h08, "rot_cw_left");
        add(0, 11'h01C, 32'h0000_0002, 2'b11, 16'h0001, 8'h01, "rot_180_left");
        add(0, 11'h01C, 32'h0000_0002, 2'b10, 16'h0004, 8'h04, "rot_ccw_left");
        add(0, 11'h01C, 32'h0002_0070, 2'b01, 16'h0870, 8'h70, "rot_p2_buttons");
        add(0, 11'h674, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "set_right");
        add(0, 11'h26B, 32'h0000_0000, 2'b00, 16'h0001, 8'h01, "set_left");
        add(0, 11'h672, 32'h0000_0000, 2'b00, 16'h0003, 8'h03, "set_down");
        add(0, 11'h275, 32'h0000_0000, 2'b00, 16'h0007, 8'h07, "set_up");
        add(0, 11'h629, 32'h0000_0000, 2'b00, 16'h000F, 8'h0F, "set_fire");
        add(0, 11'h216, 32'h0000_0000, 2'b00, 16'h001F, 8'h1F, "set_start");
        add(0, 11'h603, 32'h0000_0000, 2'b00, 16'h003F, 8'h3F, "set_skip");
        add(1, 11'h603, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "reset_latches");
        add(0, 11'h603, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "post_reset");
        add(0, 11'h603, 32'h0000_0000, 2'b00, 16'h0000, 8'h00, "no_spurious_event");

        foreach (vecs[i]) begin
            RESET   = vecs[i].rst;
            ps2_key = vecs[i].ps2;
            joy     = vecs[i].joy;
            rotate  = vecs[i].rot;
            tick();
            check(vecs[i].name, 32'(btn), 32'(vecs[i].exp));
            check({vecs[i].name, "_np1"}, 32'(btn1), 32'(vecs[i].exp1));
        end

        // Coin key held 100 cycles, released at 5 and pressed again at 10.
        ps2_key  = 11'h22E;
        hi       = 0;
        hi1      = 0;
        first_hi = -1;
        for (int i = 0; i < 100; i++) begin
            if (i == 5)  ps2_key = 11'h42E;
            if (i == 10) ps2_key = 11'h22E;
            tick();
            if (btn[7]) begin
                hi++;
                if (first_hi < 0) first_hi = i;
            end
            if (btn1[7]) hi1++;
        end
        check("coin_pulse_len", 32'(hi), 32'(COIN_PULSE));
        check("coin_pulse_len_np1", 32'(hi1), 32'(COIN_PULSE));
        check("coin_key_latency", 32'(first_hi), 32'd1);
        ps2_key = 11'h42E;
        tick();
        tick();

        // Joystick coin, then reset mid-pulse.
        joy = 32'h0080_0000;
        tick();
        check("coin_joy_p2", 32'(btn[15]), 32'd1);
        tick();
        RESET = 1'b1;
        joy   = '0;
        tick();
        check("coin_reset_cut", 32'(btn[15]), 32'd0);
        RESET = 1'b0;
        tick();
        check("after_coin_reset", 32'(btn), 32'd0);

`ifdef AUTOFIRE_EN
        // P1 autofire on, P2 off, both fire held over 8 vblank rising edges.
        af_mask = 2'b01;
        joy     = 32'h0010_0010;
        tick();
        check("af_start_high", 32'(btn[4]), 32'd1);
        check("af_p2_on", 32'(btn[12]), 32'd1);
        prev4  = btn[4];
        tog    = 0;
        steady = 1'b1;
        for (int e = 0; e < 8; e++) begin
            for (int h = 0; h < 2; h++) begin
                vblank = (h == 0);
                tick();
                if (btn[4] != prev4) tog++;
                prev4 = btn[4];
                if (!btn[12]) steady = 1'b0;
            end
        end
        check("af_p1_toggles", 32'(tog), 32'd4);
        check("af_p2_steady", 32'(steady), 32'd1);
        joy = '0;
        tick();
        check("af_release", 32'(btn[4]), 32'd0);
        af_mask = 2'b00;
        RESET   = 1'b1;
        tick();
        RESET   = 1'b0;
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            joy = ($urandom & 32'h007F_007F) | (joy & 32'h0080_0080);
            if ($urandom_range(0, 15) == 0) joy[7]  = ~joy[7];
            if ($urandom_range(0, 15) == 0) joy[23] = ~joy[23];
            if ($urandom_range(0, 9) == 0) rotate = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ps2_key[10]  = ~ps2_key[10];
                ps2_key[9]   = 1'($urandom_range(0, 1));
                ps2_key[8:0] = codes[$urandom_range(0, 23)];
            end else if ($urandom_range(0, 3) == 0) begin
                ps2_key[8:0] = codes[$urandom_range(0, 23)];
            end
            RESET = ($urandom_range(0, 299) == 0);
`ifndef AUTOFIRE_EN
            vblank  = 1'($urandom);
            af_mask = 2'($urandom);
`endif
            tick();
            check("rand_btn", 32'(btn), 32'(m_exp));
            check("rand_btn_np1", 32'(btn1), 32'(m_exp[7:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
